// File: rtl/apb_master.sv
// apb_master: single-initiator APB4 master.
//
// Accepts requests on a valid/ready port and runs them as APB SETUP/ACCESS
// transfers. Each completed transfer returns read data and error status on a
// one-cycle response strobe.
//
// Ports:
//   PRESETn, PCLK          asynchronous active-low reset, clock
//   req_valid/req_ready    request handshake (accepted when both high)
//   req_addr, req_write, req_wdata, req_strb, req_prot
//                          request fields, captured on acceptance
//   rsp_valid              one-cycle response strobe (no back-pressure)
//   rsp_rdata, rsp_err     read data (0 for writes), PSLVERR or timeout;
//                          both hold until the next response
//   PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT, PWDATA
//                          APB requester outputs, all registered
//   PRDATA, PREADY, PSLVERR
//                          APB completer inputs
//
// Build option:
//   APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees no PREADY
//                          for TIMEOUT_CYCLES cycles is aborted and answered
//                          with rsp_err=1. Undefined: ACCESS waits forever.

module apb_master #(
    parameter int PADDR_SIZE     = 32,
    parameter int PDATA_SIZE     = 32,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                      PRESETn,
    input  logic                      PCLK,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [PADDR_SIZE-1:0]     req_addr,
    input  logic                      req_write,
    input  logic [PDATA_SIZE-1:0]     req_wdata,
    input  logic [PDATA_SIZE/8-1:0]   req_strb,
    input  logic [2:0]                req_prot,

    output logic                      rsp_valid,
    output logic [PDATA_SIZE-1:0]     rsp_rdata,
    output logic                      rsp_err,

    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [PADDR_SIZE-1:0]     PADDR,
    output logic                      PWRITE,
    output logic [PDATA_SIZE/8-1:0]   PSTRB,
    output logic [2:0]                PPROT,
    output logic [PDATA_SIZE-1:0]     PWDATA,
    input  logic [PDATA_SIZE-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int SW = PDATA_SIZE / 8;

    if ((PDATA_SIZE % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master: PDATA_SIZE must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [PADDR_SIZE-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [SW-1:0]           pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [PDATA_SIZE-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PDATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    ready;
    logic                    accept;
    logic                    tmo_expired;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]           tmo_q, tmo_d;

    // The counter reads 1 in the last permitted wait cycle; PREADY in that
    // same cycle still wins over the abort.
    assign tmo_expired = (state_q == ACCESS) && !PREADY && (tmo_q == TW'(1));
`else
    assign tmo_expired = 1'b0;
`endif

    // Ready depends only on state and PREADY, never on req_valid. PRESETn
    // gating keeps it low while reset is held.
    assign ready  = PRESETn && ((state_q == IDLE) || ((state_q == ACCESS) && PREADY));
    assign accept = ready && req_valid;

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            IDLE: begin
                // Acceptance handled below.
            end

            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_d     = TW'(TIMEOUT_CYCLES);
`endif
            end

            ACCESS: begin
                if (PREADY || tmo_expired) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
                    rsp_err_d   = PREADY ? PSLVERR : 1'b1;
                    // Return to IDLE; an accepted follow-on request below
                    // overrides this and goes straight to SETUP.
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pstrb_d     = '0;
                    pwdata_d    = '0;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q - TW'(1);
                end
`endif
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        if (accept) begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = req_addr;
            pwrite_d  = req_write;
            pprot_d   = req_prot;
            // Reads drive all-zero strobes and data.
            pstrb_d   = req_write ? req_strb  : '0;
            pwdata_d  = req_write ? req_wdata : '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign req_ready = ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master
// (32-bit address/data, TIMEOUT_CYCLES=4 for the optional timeout build).

module tb_apb_master;

    logic        PRESETn;
    logic        PCLK;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    logic [108:0] outs;
    assign outs = {req_ready, rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE,
                   PADDR, PWRITE, PSTRB, PPROT, PWDATA};

    apb_master #(
        .PADDR_SIZE     (32),
        .PDATA_SIZE     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .PRESETn   (PRESETn),
        .PCLK      (PCLK),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset;
        PRESETn = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        req_strb = '0; req_prot = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        step;
        n_checks++;
        if ({req_ready, PSEL, PENABLE, rsp_valid} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_idle: got %b expected 1000",
                               {req_ready, PSEL, PENABLE, rsp_valid});
        end
    endtask

    task automatic test_single_write;
        req_addr = 32'h100; req_write = 1'b1; req_wdata = 32'hDEADBEEF;
        req_strb = 4'hF; req_prot = 3'b010; req_valid = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_ready_idle: got %b expected 1", req_ready);
        end
        step; // cycle 1: SETUP
        req_valid = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, req_ready} !== 3'b100) begin
            n_fail++; $display("FAIL wr_c1_ctrl: got %b expected 100", {PSEL, PENABLE, req_ready});
        end
        n_checks++;
        if ({PADDR, PWRITE, PWDATA, PSTRB, PPROT} !== {32'h100, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010}) begin
            n_fail++; $display("FAIL wr_c1_fields: got %h expected %h",
                {PADDR, PWRITE, PWDATA, PSTRB, PPROT}, {32'h100, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010});
        end
        step; // cycle 2: ACCESS, completes
        n_checks++;
        if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b1110) begin
            n_fail++; $display("FAIL wr_c2_ctrl: got %b expected 1110",
                               {PSEL, PENABLE, req_ready, rsp_valid});
        end
        step; // cycle 3: response
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL wr_rsp: got %h expected %h",
                               {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        end
        n_checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PPROT, PWDATA, PSTRB} !==
            {2'b00, 32'h100, 1'b1, 3'b010, 32'h0, 4'h0}) begin
            n_fail++; $display("FAIL wr_idle_fields: got %h expected %h",
                {PSEL, PENABLE, PADDR, PWRITE, PPROT, PWDATA, PSTRB},
                {2'b00, 32'h100, 1'b1, 3'b010, 32'h0, 4'h0});
        end
        step;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp_one_cycle: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait;
        req_addr = 32'h204; req_write = 1'b0; req_wdata = 32'hAAAAAAAA;
        req_strb = 4'hF; req_prot = 3'b001; req_valid = 1'b1;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h12345678;
        step; // SETUP
        req_valid = 1'b0;
        n_checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT} !==
            {2'b10, 32'h204, 1'b0, 32'h0, 4'h0, 3'b001}) begin
            n_fail++; $display("FAIL rd_setup_fields: got %h expected %h",
                {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT},
                {2'b10, 32'h204, 1'b0, 32'h0, 4'h0, 3'b001});
        end
        for (int i = 0; i < 4; i++) begin
            step; // ACCESS cycle i+1
            n_checks++;
            if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, rsp_valid} !==
                {2'b11, 32'h204, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0}) begin
                n_fail++; $display("FAIL rd_access_stable[%0d]: got %h expected %h", i,
                    {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, rsp_valid},
                    {2'b11, 32'h204, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0});
            end
            PREADY = (i == 3);
            #1;
            n_checks++;
            if (req_ready !== (i == 3)) begin
                n_fail++; $display("FAIL rd_ready[%0d]: got %b expected %b", i, req_ready, (i == 3));
            end
        end
        step; // response
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL} !== {1'b1, 1'b0, 32'h12345678, 1'b0}) begin
            n_fail++; $display("FAIL rd_rsp: got %h expected %h",
                {rsp_valid, rsp_err, rsp_rdata, PSEL}, {1'b1, 1'b0, 32'h12345678, 1'b0});
        end
        PRDATA = 32'h0; PREADY = 1'b0;
        step;
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h12345678}) begin
            n_fail++; $display("FAIL rd_rsp_hold: got %h expected %h",
                {rsp_valid, rsp_rdata}, {1'b0, 32'h12345678});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        req_addr = 32'h10; req_write = 1'b1; req_wdata = 32'h11110000;
        req_strb = 4'h3; req_prot = 3'b000; req_valid = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            step;
            exp_addr = 32'h10 + 32'(4 * ((cyc - 1) / 2));
            exp_data = 32'h11110000 + 32'((cyc - 1) / 2);
            n_checks++;
            if ({PSEL, PENABLE, PADDR, PWDATA} !== {1'b1, (cyc % 2 == 0), exp_addr, exp_data}) begin
                n_fail++; $display("FAIL b2b_bus[c%0d]: got %h expected %h", cyc,
                    {PSEL, PENABLE, PADDR, PWDATA}, {1'b1, (cyc % 2 == 0), exp_addr, exp_data});
            end
            n_checks++;
            if (rsp_valid !== (cyc == 3 || cyc == 5)) begin
                n_fail++; $display("FAIL b2b_rsp[c%0d]: got %b expected %b", cyc,
                    rsp_valid, (cyc == 3 || cyc == 5));
            end
            if (cyc % 2 == 1) begin
                if ((cyc + 1) / 2 < 3) begin
                    req_addr  = 32'h10 + 32'(4 * ((cyc + 1) / 2));
                    req_wdata = 32'h11110000 + 32'((cyc + 1) / 2);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        step; // cycle 7
        n_checks++;
        if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_last_rsp: got %b expected 100", {rsp_valid, PSEL, PENABLE});
        end
        step;
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_slverr;
        req_addr = 32'h300; req_write = 1'b0; req_prot = 3'b000; req_valid = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h55AA55AA;
        step; req_valid = 1'b0;
        step;
        step; // response
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h55AA55AA}) begin
            n_fail++; $display("FAIL err_rsp: got %h expected %h",
                {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h55AA55AA});
        end
        PSLVERR = 1'b0;
        req_addr = 32'h304; req_write = 1'b1; req_wdata = 32'h11; req_strb = 4'h1; req_valid = 1'b1;
        step; req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err} !== 2'b01) begin
            n_fail++; $display("FAIL err_single_pulse: got %b expected 01", {rsp_valid, rsp_err});
        end
        step;
        step; // response of the write
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL err_clear_rsp: got %h expected %h",
                {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        end
        step;
    endtask

    task automatic test_reset_mid;
        req_addr = 32'h700; req_write = 1'b1; req_wdata = 32'h77; req_strb = 4'hF;
        req_prot = 3'b100; req_valid = 1'b1; PREADY = 1'b0;
        step; req_valid = 1'b0;
        step; // ACCESS
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_access: got %b expected 11", {PSEL, PENABLE});
        end
        #3;
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", outs);
        end
        step;
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL rst_mid_held: got %h expected 0", outs);
        end
        @(negedge PCLK);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        step;
        n_checks++;
        if ({rsp_valid, req_ready, PSEL} !== 3'b010) begin
            n_fail++; $display("FAIL rst_mid_no_rsp: got %b expected 010", {rsp_valid, req_ready, PSEL});
        end
        req_addr = 32'h40; req_write = 1'b0; req_valid = 1'b1; PRDATA = 32'h0BADCAFE;
        step; req_valid = 1'b0;
        step;
        step;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0BADCAFE}) begin
            n_fail++; $display("FAIL rst_mid_read: got %h expected %h",
                {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BADCAFE});
        end
        step;
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        req_addr = 32'h500; req_write = 1'b0; req_prot = 3'b000; req_valid = 1'b1;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF0000;
        step; // SETUP; keep a second request waiting
        req_addr = 32'h600;
        for (int i = 0; i < 4; i++) begin
            step;
            n_checks++;
            if ({PSEL, PENABLE, rsp_valid, PADDR} !== {3'b110, 32'h500}) begin
                n_fail++; $display("FAIL tmo_wait[%0d]: got %h expected %h", i,
                    {PSEL, PENABLE, rsp_valid, PADDR}, {3'b110, 32'h500});
            end
        end
        step; // after abort
        n_checks++;
        if ({PSEL, PENABLE, PADDR} !== {2'b00, 32'h500}) begin
            n_fail++; $display("FAIL tmo_abort_bus: got %h expected %h",
                {PSEL, PENABLE, PADDR}, {2'b00, 32'h500});
        end
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL tmo_rsp: got %h expected %h",
                {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
        end
        step; // pending request accepted from IDLE
        req_valid = 1'b0; PREADY = 1'b1;
        n_checks++;
        if ({PSEL, PENABLE, PADDR, rsp_valid} !== {2'b10, 32'h600, 1'b0}) begin
            n_fail++; $display("FAIL tmo_next_setup: got %h expected %h",
                {PSEL, PENABLE, PADDR, rsp_valid}, {2'b10, 32'h600, 1'b0});
        end
        step;
        step;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFF0000}) begin
            n_fail++; $display("FAIL tmo_next_rsp: got %h expected %h",
                {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hFFFF0000});
        end
        step;
    endtask
`endif

    initial begin
        test_reset;
        test_single_write;
        test_read_wait;
        test_back_to_back;
        test_slverr;
        test_reset_mid;
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-initiator APB4 master.
- Converts a simple valid/ready request port into APB SETUP/ACCESS transfers and returns read data and error status on a one-cycle response strobe.
- Sits between a local controller (a bridge, DMA or test sequencer) and an APB slave or decoder.
- Drives every signal that the team's APB protocol checker monitors.

Parameters:
- PADDR_SIZE, 32, PADDR/req_addr width
- PDATA_SIZE, 32, PWDATA/PRDATA width; must be a multiple of 8
- TIMEOUT_CYCLES, 128, ACCESS-phase cycles before abort; used only with APB_MASTER_TIMEOUT_EN; must be >= 1

Ports:
- PRESETn  in  1  asynchronous active-low reset
- PCLK  in  1  clock
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready
- req_addr  in  PADDR_SIZE  transfer address
- req_write  in  1  1=write, 0=read
- req_wdata  in  PDATA_SIZE  write data
- req_strb  in  PDATA_SIZE/8  write byte strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  PDATA_SIZE  read data (0 for writes)
- rsp_err  out  1  PSLVERR or timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  PADDR_SIZE  APB address
- PWRITE  out  1  APB direction
- PSTRB  out  PDATA_SIZE/8  APB strobes
- PPROT  out  3  APB protection
- PWDATA  out  PDATA_SIZE  APB write data
- PRDATA  in  PDATA_SIZE  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async, PRESETn low): state=IDLE; all outputs 0, including req_ready and rsp_valid.
- Reset mid-transfer: aborts immediately with no response. The next request starts after PRESETn deasserts.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1.
  - On req_valid: register addr/write/wdata/strb/prot onto PADDR..PWDATA, set PSEL=1, PENABLE=0, go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, go to ACCESS.
- ACCESS: holds until PREADY=1. PADDR, PWRITE, PSTRB, PPROT, PWDATA, PSEL stay stable throughout.
- Completion cycle (ACCESS & PREADY):
  - Next cycle: rsp_valid=1 for exactly one cycle.
  - rsp_rdata = PRDATA sampled at completion for reads, 0 for writes.
  - rsp_err = PSLVERR sampled at completion.
- Back-to-back transfers: req_ready = IDLE | (ACCESS & PREADY).
  - This is combinational on PREADY; no combinational path from req_valid to req_ready.
  - If req_valid is high in the completion cycle: go directly to SETUP with new fields, PSEL held 1, PENABLE=0. No idle cycle in between.
  - Otherwise: go to IDLE, PSEL=0, PENABLE=0.
- Address and data fields on return to IDLE: PADDR/PPROT/PWRITE hold their last values. PWDATA and PSTRB are cleared to 0.
- Reads: PSTRB driven all-zero (APB4 rule) regardless of req_strb. PWDATA driven 0.
- Latency: minimum 2 PCLK from acceptance to completion; response 1 cycle later.
  - Zero-wait-state throughput: one transfer per 2 cycles.
- Response handshake: none. The consumer must accept rsp_valid when it is presented.
- rsp_rdata and rsp_err hold their values until the next response.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN
- Defined:
  - A counter loads TIMEOUT_CYCLES on entry to ACCESS and decrements each ACCESS cycle without PREADY.
  - If it reaches 0 with PREADY still low, the transfer is aborted: PSEL=0, PENABLE=0, go to IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0. A req_valid present in the abort cycle is not accepted.
  - If PREADY=1 in the same cycle the counter reaches 0, the transfer completes normally.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Single write, addr=0x100, wdata=0xDEADBEEF, strb=0xF, PREADY=1 in first ACCESS cycle:
  - PSEL rises cycle 1, PENABLE cycle 2, completes cycle 2.
  - rsp_valid cycle 3 with rsp_err=0, rsp_rdata=0.
- Read, addr=0x204, slave inserts 3 wait states, PRDATA=0x12345678:
  - PSTRB=0 throughout; all APB outputs stable for 4 ACCESS cycles.
  - rsp_rdata=0x12345678.
- Three back-to-back writes with req_valid held high, PREADY=1:
  - PSEL stays 1 for 6 cycles; PENABLE toggles 0,1,0,1,0,1.
  - 3 rsp_valid pulses spaced 2 cycles apart.
- Read completes with PSLVERR=1: rsp_err=1 for exactly one rsp_valid pulse; next transfer with PSLVERR=0 returns rsp_err=0.
- PRESETn asserted during ACCESS of a write: all outputs 0 immediately, no rsp_valid. After release, a new read completes correctly.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY held 0:
  - Abort after 4 ACCESS cycles, PSEL=0.
  - rsp_valid=1 with rsp_err=1, rsp_rdata=0.
